axi_gp_initiator: RTL and testbench
===================================

AXI_GP_INITIATOR -- requirements
Module: axi_gp_initiator

Interface
REQ-001 SHALL have parameter AXI_ID, default 12'h0, the fixed ID driven on awid, wid and arid and expected back on bid and rid.
REQ-002 SHALL have ports: aclk  in  1  clock; all logic on the rising edge.
REQ-003 arst  in  1  asynchronous, active-high reset.
REQ-004 cmd_addr  in  32  byte address; bits [1:0] are ignored and driven as 0.
REQ-005 cmd_wdata  in  32  write data.
REQ-006 cmd_wstb  in  4  write byte strobes.
REQ-007 cmd_wr  in  1  1=write, 0=read.
REQ-008 cmd_valid  in  1  command request.
REQ-009 cmd_ready  out  1  high only in IDLE.
REQ-010 resp_data  out  32  read data; 0 after a write.
REQ-011 resp_status  out  3  {id_or_last_error, xresp[1:0]}.
REQ-012 resp_valid  out  1  one-cycle completion pulse.
REQ-013 awaddr/awvalid/awready: out 32 / out 1 / in 1; AXI3 write address.
REQ-014 wdata/wstb/wvalid/wready/wlast: out 32 / out 4 / out 1 / in 1 / out 1; AXI3 write data.
REQ-015 bresp/bid/bvalid/bready: in 2 / in 12 / in 1 / out 1; write response.
REQ-016 araddr/arvalid/arready: out 32 / out 1 / in 1; read address.
REQ-017 rdata/rresp/rid/rlast/rvalid/rready: in 32 / in 2 / in 12 / in 1 / in 1 / out 1; read data.
REQ-018 awid, wid, arid  out  12  = AXI_ID; awlen, arlen out 4 = 0; awsize, arsize out 2 = 2'b10; awburst, arburst out 2 = 2'b01; wlast = 1 whenever wvalid.

Function
REQ-019 SHALL implement the states IDLE, WR (address/data phase), WR_RESP, RD_ADDR and RD_DATA, with at most one transaction outstanding.
REQ-020 In IDLE, a command is accepted when cmd_valid && cmd_ready; on the next cycle it SHALL drive the command fields onto the AXI signals and register them, and enter WR (cmd_wr=1) or RD_ADDR (cmd_wr=0).
REQ-021 In WR, awvalid and wvalid SHALL both assert on state entry; each SHALL deassert independently on the cycle after its own ready is sampled high; awaddr, wdata and wstb SHALL be stable while the corresponding valid is high.
REQ-022 WR SHALL go to WR_RESP once both the AW and W handshakes have completed, in either order or in the same cycle.
REQ-023 bready SHALL be 1 only in WR_RESP; on bvalid the block SHALL return to IDLE and pulse resp_valid with resp_status = {bid!=AXI_ID, bresp} and resp_data=0.
REQ-024 In RD_ADDR, arvalid SHALL be held until arready, then the block SHALL enter RD_DATA.
REQ-025 rready SHALL be 1 only in RD_DATA; on rvalid the block SHALL capture rdata into resp_data, set resp_status = {(rid!=AXI_ID)|!rlast, rresp}, pulse resp_valid and return to IDLE.
REQ-026 The minimum write latency SHALL be 3 cycles and the minimum read latency SHALL be 3 cycles, each measured from the cmd accept edge to resp_valid when the slave responds with zero wait states.
REQ-027 resp_valid SHALL NOT be back-pressured; resp_data and resp_status SHALL hold until the next completion.
REQ-028 There SHALL be no timeout: the block SHALL wait indefinitely for a handshake and SHALL never drop a valid it has already asserted.
REQ-029 cmd_valid in states other than IDLE SHALL be ignored, because cmd_ready is low.
REQ-030 A bvalid or rvalid arriving outside its response state SHALL NOT be acknowledged, since bready and rready are low.

Reset
REQ-031 While arst is high, the block SHALL be in IDLE with cmd_ready=1, and awvalid, wvalid, arvalid, bready, rready and resp_valid SHALL all be 0, and resp_data=0 and resp_status=0.
REQ-032 arst asserted mid-transaction SHALL drop all valids immediately (asynchronously), and any in-flight response SHALL be discarded.

Verification
REQ-033 Write 0x0000_0120 / 0xDEADBEEF / wstb=4'hF against a zero-wait slave -> a single AW and a single W handshake, then bready, then resp_valid on the 3rd cycle with status 3'b000.
REQ-034 Read 0x0000_0124 where the slave returns 0x12345678 with rlast=1 -> resp_data=0x12345678, status 3'b000.
REQ-035 Write where awready is delayed 5 cycles and wready arrives immediately -> wvalid drops after 1 cycle, awvalid holds 5 cycles, exactly one B is accepted.
REQ-036 Read where the slave returns rresp=2'b10 and rid=AXI_ID+1 -> resp_status=3'b110.
REQ-037 arst pulsed while in WR_RESP -> all outputs take their reset values immediately, and the next command completes normally.
REQ-038 cmd_valid held high for 3 back-to-back commands -> exactly 3 are accepted, each only while in IDLE, and they complete in order.

Source files
------------

// File: rtl/axi_gp_initiator.sv
// Single-beat AXI3 initiator: turns one 32-bit command at a time into an
// AW/W/B write or AR/R read and reports the outcome as a one-cycle pulse.
module axi_gp_initiator #(
   parameter logic [11:0] AXI_ID = 12'h0
) (
   input  logic        aclk,
   input  logic        arst,
   // command side
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   input  logic [3:0]  cmd_wstb,
   input  logic        cmd_wr,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   output logic [31:0] resp_data,
   output logic [2:0]  resp_status,
   output logic        resp_valid,
   // write address
   output logic [11:0] awid,
   output logic [31:0] awaddr,
   output logic [3:0]  awlen,
   output logic [1:0]  awsize,
   output logic [1:0]  awburst,
   output logic        awvalid,
   input  logic        awready,
   // write data
   output logic [11:0] wid,
   output logic [31:0] wdata,
   output logic [3:0]  wstb,
   output logic        wlast,
   output logic        wvalid,
   input  logic        wready,
   // write response
   input  logic [1:0]  bresp,
   input  logic [11:0] bid,
   input  logic        bvalid,
   output logic        bready,
   // read address
   output logic [11:0] arid,
   output logic [31:0] araddr,
   output logic [3:0]  arlen,
   output logic [1:0]  arsize,
   output logic [1:0]  arburst,
   output logic        arvalid,
   input  logic        arready,
   // read data
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic [11:0] rid,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR      = 3'd1,
      WR_RESP = 3'd2,
      RD_ADDR = 3'd3,
      RD_DATA = 3'd4
   } state_t;

   state_t      state_q;
   logic        awvalid_q, wvalid_q, arvalid_q;
   logic [31:0] addr_q, wdata_q;
   logic [3:0]  wstb_q;
   logic        resp_valid_q;
   logic [31:0] resp_data_q;
   logic [2:0]  resp_status_q;
   logic        aw_fin, w_fin;

   // A channel counts as finished once its valid is gone or is being taken now
   always_comb begin
      aw_fin = !awvalid_q || awready;
      w_fin  = !wvalid_q  || wready;
   end

   // Transaction FSM: one command in flight, all AXI valids and results registered
   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         state_q       <= IDLE;
         awvalid_q     <= 1'b0;
         wvalid_q      <= 1'b0;
         arvalid_q     <= 1'b0;
         addr_q        <= 32'h0;
         wdata_q       <= 32'h0;
         wstb_q        <= 4'h0;
         resp_valid_q  <= 1'b0;
         resp_data_q   <= 32'h0;
         resp_status_q <= 3'h0;
      end else begin
         resp_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (cmd_valid) begin
                  // byte-lane bits are not carried: every access is word aligned
                  addr_q <= cmd_addr & 32'hFFFF_FFFC;
                  if (cmd_wr) begin
                     wdata_q   <= cmd_wdata;
                     wstb_q    <= cmd_wstb;
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                     state_q   <= WR;
                  end else begin
                     arvalid_q <= 1'b1;
                     state_q   <= RD_ADDR;
                  end
               end
            end
            WR: begin
               // AW and W retire independently; move on when both are done
               if (awvalid_q && awready) awvalid_q <= 1'b0;
               if (wvalid_q && wready)   wvalid_q  <= 1'b0;
               if (aw_fin && w_fin)      state_q   <= WR_RESP;
            end
            WR_RESP: begin
               if (bvalid) begin
                  resp_valid_q  <= 1'b1;
                  resp_data_q   <= 32'h0;
                  resp_status_q <= {bid != AXI_ID, bresp};
                  state_q       <= IDLE;
               end
            end
            RD_ADDR: begin
               if (arready) begin
                  arvalid_q <= 1'b0;
                  state_q   <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (rvalid) begin
                  resp_valid_q  <= 1'b1;
                  resp_data_q   <= rdata;
                  resp_status_q <= {(rid != AXI_ID) || !rlast, rresp};
                  state_q       <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cmd_ready   = (state_q == IDLE);
   assign bready      = (state_q == WR_RESP);
   assign rready      = (state_q == RD_DATA);
   assign resp_valid  = resp_valid_q;
   assign resp_data   = resp_data_q;
   assign resp_status = resp_status_q;

   assign awid    = AXI_ID;
   assign awaddr  = addr_q;
   assign awlen   = 4'h0;
   assign awsize  = 2'b10;
   assign awburst = 2'b01;
   assign awvalid = awvalid_q;

   assign wid     = AXI_ID;
   assign wdata   = wdata_q;
   assign wstb    = wstb_q;
   assign wlast   = 1'b1;
   assign wvalid  = wvalid_q;

   assign arid    = AXI_ID;
   assign araddr  = addr_q;
   assign arlen   = 4'h0;
   assign arsize  = 2'b10;
   assign arburst = 2'b01;
   assign arvalid = arvalid_q;

endmodule

// File: tb/tb_axi_gp_initiator.sv
// Bench for axi_gp_initiator: a behavioural AXI slave with per-transaction
// wait states, a command scoreboard and a latency model from channel delays.
module tb_axi_gp_initiator;

   localparam logic [11:0] ID = 12'h0A5;

   logic        aclk = 1'b0;
   logic        arst = 1'b1;
   logic [31:0] cmd_addr = '0, cmd_wdata = '0;
   logic [3:0]  cmd_wstb = '0;
   logic        cmd_wr = 1'b0, cmd_valid = 1'b0;
   logic        cmd_ready, resp_valid;
   logic [31:0] resp_data;
   logic [2:0]  resp_status;
   logic [11:0] awid, wid, arid;
   logic [31:0] awaddr, wdata, araddr;
   logic [3:0]  awlen, arlen, wstb;
   logic [1:0]  awsize, awburst, arsize, arburst;
   logic        awvalid, wvalid, wlast, arvalid, bready, rready;
   logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0;
   logic        rvalid = 1'b0, rlast = 1'b0;
   logic [1:0]  bresp = '0, rresp = '0;
   logic [11:0] bid = '0, rid = '0;
   logic [31:0] rdata = '0;

   axi_gp_initiator #(.AXI_ID(ID)) dut (
      .aclk(aclk), .arst(arst),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstb(cmd_wstb),
      .cmd_wr(cmd_wr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .resp_data(resp_data), .resp_status(resp_status), .resp_valid(resp_valid),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
      .awburst(awburst), .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstb(wstb), .wlast(wlast),
      .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bid(bid), .bvalid(bvalid), .bready(bready),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
      .arburst(arburst), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rid(rid), .rlast(rlast),
      .rvalid(rvalid), .rready(rready)
   );

   always #5 aclk = ~aclk;

   int total = 0, bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // slave behaviour for the current transaction
   int          cfg_aw = 0, cfg_w = 0, cfg_b = 0, cfg_ar = 0, cfg_r = 0;
   logic [1:0]  cfg_bresp = '0, cfg_rresp = '0;
   logic [11:0] cfg_bid = ID, cfg_rid = ID;
   logic [31:0] cfg_rdata = '0;
   logic        cfg_rlast = 1'b1, cfg_spur_b = 1'b0, cfg_spur_r = 1'b0;

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstb;
   } cmd_t;
   cmd_t acc_q[$];

   int   cyc = 0, stamp = 0, n_resp = 0, n_acc = 0;
   int   n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0, aw_cyc = 0, w_cyc = 0;
   int   aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
   logic aw_ok = 0, w_ok = 0, ar_ok = 0;
   logic p_aw = 0, p_w = 0, p_b = 0, p_ar = 0, p_r = 0;
   logic prev_awv = 0, prev_wv = 0, prev_arv = 0, prev_rv = 0;
   logic [31:0] prev_awaddr = '0, prev_wdata = '0, prev_araddr = '0;
   logic [3:0]  prev_wstb = '0;
   logic [31:0] last_data = '0;
   logic [2:0]  last_status = '0;
   int          last_lat = 0;

   // Slave + monitor: every negedge retire the handshakes predicted last time,
   // check the initiator against the scoreboard, then drive the next slave cycle.
   always @(negedge aclk) begin
      cmd_t c;
      logic        wr_out;
      logic [31:0] ed;
      logic [2:0]  es;
      int          el;
      cyc++;
      if (arst) begin
         awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
         aw_ok = 0; w_ok = 0; ar_ok = 0;
         aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
         p_aw = 0; p_w = 0; p_b = 0; p_ar = 0; p_r = 0;
         n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0; aw_cyc = 0; w_cyc = 0;
         prev_awv = 0; prev_wv = 0; prev_arv = 0; prev_rv = 0;
         last_data = 0; last_status = 0;
         acc_q.delete();
      end else begin
         // an asserted valid may only go away through its handshake
         if (prev_awv && !p_aw) begin
            chk("aw_hold", 64'(awvalid), 64'(1));
            chk("aw_stable", 64'(awaddr), 64'(prev_awaddr));
         end
         if (prev_wv && !p_w) begin
            chk("w_hold", 64'(wvalid), 64'(1));
            chk("w_stable", {28'h0, prev_wstb, prev_wdata} ^ {28'h0, wstb, wdata}, 64'(0));
         end
         if (prev_arv && !p_ar) begin
            chk("ar_hold", 64'(arvalid), 64'(1));
            chk("ar_stable", 64'(araddr), 64'(prev_araddr));
         end
         if (p_aw) begin aw_ok = 1; n_aw++; end
         if (p_w)  begin w_ok = 1; n_w++; end
         if (p_b)  begin n_b++; aw_ok = 0; w_ok = 0; b_wait = 0; end
         if (p_ar) begin ar_ok = 1; n_ar++; end
         if (p_r)  begin n_r++; ar_ok = 0; r_wait = 0; end

         wr_out = (acc_q.size() != 0) && acc_q[0].wr;
         if (awvalid) begin
            aw_cyc++;
            chk("aw_owner", 64'(wr_out), 64'(1));
            if (wr_out) chk("awaddr", 64'(awaddr), 64'({acc_q[0].addr[31:2], 2'b00}));
            chk("aw_const", 64'({awid, awlen, awsize, awburst}), 64'({ID, 4'h0, 2'b10, 2'b01}));
         end
         if (wvalid) begin
            w_cyc++;
            chk("w_owner", 64'(wr_out), 64'(1));
            if (wr_out) chk("wdata_wstb", 64'({wstb, wdata}), 64'({acc_q[0].wstb, acc_q[0].wdata}));
            chk("w_const", 64'({wid, wlast}), 64'({ID, 1'b1}));
         end
         if (arvalid) begin
            chk("ar_owner", 64'((acc_q.size() != 0) && !acc_q[0].wr), 64'(1));
            if (acc_q.size() != 0) chk("araddr", 64'(araddr), 64'({acc_q[0].addr[31:2], 2'b00}));
            chk("ar_const", 64'({arid, arlen, arsize, arburst}), 64'({ID, 4'h0, 2'b10, 2'b01}));
         end
         chk("bready", 64'(bready), 64'(wr_out && aw_ok && w_ok));
         chk("rready", 64'(rready), 64'((acc_q.size() != 0) && !acc_q[0].wr && ar_ok));

         if (resp_valid) begin
            chk("resp_pulse", 64'(prev_rv), 64'(0));
            chk("resp_owner", 64'(acc_q.size() != 0), 64'(1));
            if (acc_q.size() != 0) begin
               c = acc_q.pop_front();
               if (c.wr) begin
                  ed = 0;
                  es = {cfg_bid != ID, cfg_bresp};
                  el = 3 + ((cfg_aw > cfg_w) ? cfg_aw : cfg_w) + cfg_b;
                  chk("aw_cycles", 64'(aw_cyc), 64'(cfg_aw + 1));
                  chk("w_cycles", 64'(w_cyc), 64'(cfg_w + 1));
               end else begin
                  ed = cfg_rdata;
                  es = {(cfg_rid != ID) || !cfg_rlast, cfg_rresp};
                  el = 3 + cfg_ar + cfg_r;
               end
               chk("resp_data", 64'(resp_data), 64'(ed));
               chk("resp_status", 64'(resp_status), 64'(es));
               chk("latency", 64'(cyc - stamp), 64'(el));
               chk("hs_counts", 64'(n_aw*10000 + n_w*1000 + n_b*100 + n_ar*10 + n_r),
                   64'(c.wr ? 11100 : 11));
            end
            n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0; aw_cyc = 0; w_cyc = 0;
            last_data = resp_data; last_status = resp_status; last_lat = cyc - stamp;
            n_resp++;
         end else begin
            chk("resp_hold", 64'({resp_status, resp_data}), 64'({last_status, last_data}));
         end
         chk("cmd_ready", 64'(cmd_ready), 64'(acc_q.size() == 0));

         if (cmd_valid && cmd_ready) begin
            acc_q.push_back('{cmd_wr, cmd_addr, cmd_wdata, cmd_wstb});
            stamp = cyc;
            n_acc++;
         end

         awready = awvalid && (aw_wait >= cfg_aw);
         if (awvalid && !awready) aw_wait++;
         if (awready) aw_wait = 0;
         wready = wvalid && (w_wait >= cfg_w);
         if (wvalid && !wready) w_wait++;
         if (wready) w_wait = 0;
         bvalid = (aw_ok && w_ok && (b_wait >= cfg_b)) || cfg_spur_b;
         if (aw_ok && w_ok && !(b_wait >= cfg_b)) b_wait++;
         bresp = cfg_bresp; bid = cfg_bid;
         arready = arvalid && (ar_wait >= cfg_ar);
         if (arvalid && !arready) ar_wait++;
         if (arready) ar_wait = 0;
         rvalid = (ar_ok && (r_wait >= cfg_r)) || cfg_spur_r;
         if (ar_ok && !(r_wait >= cfg_r)) r_wait++;
         rdata = cfg_rdata; rresp = cfg_rresp; rid = cfg_rid; rlast = cfg_rlast;

         p_aw = awvalid && awready;
         p_w  = wvalid && wready;
         p_b  = bvalid && bready;
         p_ar = arvalid && arready;
         p_r  = rvalid && rready;
         prev_awv = awvalid; prev_wv = wvalid; prev_arv = arvalid; prev_rv = resp_valid;
         prev_awaddr = awaddr; prev_wdata = wdata; prev_wstb = wstb; prev_araddr = araddr;
      end
   end

   task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      int k = 0;
      @(posedge aclk); #1;
      cmd_wr = wr; cmd_addr = a; cmd_wdata = d; cmd_wstb = s; cmd_valid = 1'b1;
      do begin @(negedge aclk); k++; end while (!cmd_ready && k < 60);
      if (k >= 60) chk("accept_timeout", 64'(0), 64'(1));
      @(posedge aclk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_resp(input int target, input string name);
      int k = 0;
      while (n_resp < target && k < 200) begin @(negedge aclk); #1; k++; end
      chk(name, 64'(n_resp), 64'(target));
   endtask

   task automatic run_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      int n0 = n_resp;
      issue(wr, a, d, s);
      wait_resp(n0 + 1, "completion");
   endtask

   task automatic set_cfg(input int aw, w, b, ar, r, input logic [31:0] rd, input logic [1:0] rr,
                          input logic [11:0] ri, input logic rl, input logic [1:0] br, input logic [11:0] bi);
      cfg_aw = aw; cfg_w = w; cfg_b = b; cfg_ar = ar; cfg_r = r;
      cfg_rdata = rd; cfg_rresp = rr; cfg_rid = ri; cfg_rlast = rl; cfg_bresp = br; cfg_bid = bi;
      cfg_spur_b = 1'b0; cfg_spur_r = 1'b0;
   endtask

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstb;
      int          aw, w, b, ar, r;
      logic [31:0] rdata;
      logic [1:0]  rresp;
      logic [11:0] rid;
      logic        rlast;
      logic [1:0]  bresp;
      logic [11:0] bid;
      logic [31:0] exp_data;
      logic [2:0]  exp_st;
      int          exp_lat;
   } vec_t;

   vec_t tbl[7];

   initial begin
      int a0, n0, acc;
      logic [31:0] rv;
      tbl[0] = '{1'b1, 32'h0000_0120, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 32'h0, 2'b00, ID, 1'b1, 2'b00, ID, 32'h0, 3'b000, 3};
      tbl[1] = '{1'b0, 32'h0000_0124, 32'h0, 4'h0, 0, 0, 0, 0, 0, 32'h12345678, 2'b00, ID, 1'b1, 2'b00, ID, 32'h12345678, 3'b000, 3};
      // awready on the 5th cycle of awvalid, wready immediately
      tbl[2] = '{1'b1, 32'h0000_0200, 32'h0BADF00D, 4'hF, 4, 0, 0, 0, 0, 32'h0, 2'b00, ID, 1'b1, 2'b00, ID, 32'h0, 3'b000, 7};
      tbl[3] = '{1'b0, 32'h0000_0300, 32'h0, 4'h0, 0, 0, 0, 0, 0, 32'hA5A5_0001, 2'b10, ID + 12'h1, 1'b1, 2'b00, ID, 32'hA5A5_0001, 3'b110, 3};
      tbl[4] = '{1'b1, 32'h0000_0123, 32'h11223344, 4'h3, 0, 3, 2, 0, 0, 32'h0, 2'b00, ID, 1'b1, 2'b11, 12'h000, 32'h0, 3'b111, 8};
      tbl[5] = '{1'b0, 32'hFFFF_FFFF, 32'h0, 4'h0, 0, 0, 0, 2, 3, 32'hCAFEF00D, 2'b01, ID, 1'b0, 2'b00, ID, 32'hCAFEF00D, 3'b101, 8};
      tbl[6] = '{1'b1, 32'h8000_0004, 32'h55AA55AA, 4'h5, 2, 2, 0, 0, 0, 32'h0, 2'b00, ID, 1'b1, 2'b01, ID, 32'h0, 3'b001, 5};

      #2;
      chk("reset_state", {24'h0, cmd_ready, awvalid, wvalid, arvalid, bready, rready, resp_valid, resp_status, resp_data},
          {24'h0, 1'b1, 6'b0, 3'b0, 32'h0});
      repeat (2) @(negedge aclk);
      @(posedge aclk); #1 arst = 1'b0;

      for (int i = 0; i < 7; i++) begin
         set_cfg(tbl[i].aw, tbl[i].w, tbl[i].b, tbl[i].ar, tbl[i].r, tbl[i].rdata, tbl[i].rresp,
                 tbl[i].rid, tbl[i].rlast, tbl[i].bresp, tbl[i].bid);
         run_cmd(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].wstb);
         chk($sformatf("vec%0d_data", i), 64'(last_data), 64'(tbl[i].exp_data));
         chk($sformatf("vec%0d_status", i), 64'(last_status), 64'(tbl[i].exp_st));
         chk($sformatf("vec%0d_lat", i), 64'(last_lat), 64'(tbl[i].exp_lat));
      end

      // reset while waiting for B: everything drops, the next command is clean
      set_cfg(0, 0, 0, 0, 0, 32'h1111_2222, 2'b00, ID, 1'b1, 2'b00, ID);
      run_cmd(1'b0, 32'h40, 32'h0, 4'h0);
      set_cfg(0, 0, 40, 0, 0, 32'h0, 2'b00, ID, 1'b1, 2'b00, ID);
      issue(1'b1, 32'h44, 32'h9999_8888, 4'hF);
      begin
         int k = 0;
         while (!bready && k < 20) begin @(negedge aclk); #1; k++; end
         chk("reach_wr_resp", 64'(bready), 64'(1));
      end
      @(posedge aclk); #3 arst = 1'b1;
      #1;
      chk("mid_reset_outs", {24'h0, cmd_ready, awvalid, wvalid, arvalid, bready, rready, resp_valid, resp_status, resp_data},
          {24'h0, 1'b1, 6'b0, 3'b0, 32'h0});
      @(negedge aclk);
      @(posedge aclk); #1 arst = 1'b0;
      set_cfg(0, 0, 0, 0, 0, 32'h0, 2'b00, ID, 1'b1, 2'b00, ID);
      run_cmd(1'b1, 32'h48, 32'h7777_6666, 4'hC);
      chk("post_reset_status", 64'(last_status), 64'(0));
      chk("post_reset_lat", 64'(last_lat), 64'(3));

      // cmd_valid held across three commands
      set_cfg(0, 1, 0, 1, 0, 32'h5555_AAAA, 2'b00, ID, 1'b1, 2'b00, ID);
      a0 = n_acc; n0 = n_resp; acc = 0;
      @(posedge aclk); #1;
      cmd_wr = 1'b1; cmd_addr = 32'h100; cmd_wdata = 32'hA0; cmd_wstb = 4'hF; cmd_valid = 1'b1;
      for (int k = 0; k < 100 && acc < 3; k++) begin
         @(negedge aclk);
         if (cmd_ready) begin
            acc++;
            @(posedge aclk); #1;
            if (acc == 1) begin cmd_wr = 1'b0; cmd_addr = 32'h104; end
            else if (acc == 2) begin cmd_wr = 1'b1; cmd_addr = 32'h108; cmd_wdata = 32'hA2; end
            else cmd_valid = 1'b0;
         end
      end
      wait_resp(n0 + 3, "b2b_done");
      chk("b2b_accepts", 64'(n_acc - a0), 64'(3));

      // randomized traffic, checked by the scoreboard
      for (int i = 0; i < 40; i++) begin
         logic wr;
         wr = 1'($urandom_range(0, 1));
         rv = $urandom;
         set_cfg($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0) ? 12'($urandom) : ID, 1'($urandom_range(0, 4) != 0),
                 2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0) ? 12'($urandom) : ID);
         if (wr) cfg_spur_r = 1'($urandom_range(0, 1));
         else    cfg_spur_b = 1'($urandom_range(0, 1));
         run_cmd(wr, rv, $urandom, 4'($urandom));
      end
      cfg_spur_b = 1'b0; cfg_spur_r = 1'b0;
      repeat (3) @(negedge aclk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
